regfile_write_arbiter: RTL and testbench

Shares the single write port of the LITE-16 `register_file` (16 × 16-bit, one-hot `en`, common `data_in`) among several writeback sources, e.g. ALU result, memory load return and debug/monitor port. It accepts at most one write per cycle through a valid/ready handshake. The grant order is round-robin, so no source starves. The block drives registered `data_in`/`en` straight into `register_file` and exports a pending-write mask that `register_fetch_unit` uses for hazard stalls.

---
 rtl/lite16_pkg.sv | 16 +
 rtl/rr_grant.sv | 54 +++++
 rtl/regfile_write_arbiter.sv | 127 ++++++++++++
 tb/tb_regfile_write_arbiter.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lite16_pkg.sv
// Shared LITE-16 definitions.
// Holds the register-file geometry constants and the helper that turns a
// register index into the one-hot write-enable vector that register_file
// expects on its en input.
package lite16_pkg;

  localparam int LITE16_WIDTH  = 16;
  localparam int LITE16_NREGS  = 16;
  localparam int LITE16_ADDR_W = 4;

  // One-hot write enable for a 16-entry register file.
  function automatic logic [LITE16_NREGS-1:0] onehot16(input logic [LITE16_ADDR_W-1:0] addr);
    return LITE16_NREGS'(1) << addr;
  endfunction

endpackage

// File: rtl/rr_grant.sv
// Combinational round-robin search.
// Scans req starting at index ptr, wrapping modulo N, and grants the first
// asserted request. Nothing is granted while enable is low.
//
// Ports:
//   req      in  N          request vector
//   ptr      in  clog2(N)   index that has highest priority this cycle
//   enable   in  1          allows a grant
//   gnt      out N          one-hot grant (zero when nothing granted)
//   gnt_idx  out clog2(N)   index of the granted request (0 when none)
//   any      out 1          a grant was issued
module rr_grant #(
  parameter int N = 3
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  input  logic                 enable,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic                 any
);

  localparam int IDX_W = $clog2(N);

  // ptr + off, wrapped into 0..N-1 (off is always below N).
  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= N) sum = sum - N;
    return IDX_W'(sum);
  endfunction

  logic [IDX_W-1:0] w_cand;

  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, otherwise the tool infers a latch.
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    w_cand  = '0;
    if (enable) begin
      for (int k = 0; k < N; k++) begin
        w_cand = wrap_add(ptr, k);
        if (!any && req[w_cand]) begin
          any          = 1'b1;
          gnt[w_cand]  = 1'b1;
          gnt_idx      = w_cand;
        end
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Write-port arbiter for the LITE-16 register file.
// Several writeback sources compete for the single register_file write port.
// One request is accepted per cycle (valid/ready), chosen round-robin so no
// source starves. The accepted write is registered and driven straight onto
// register_file.data_in/en; pending mirrors the write currently on en so
// register_fetch_unit can stall on it.
//
// Ports:
//   clk        in   1             rising-edge clock
//   rst        in   1             asynchronous reset, active low
//   hold       in   1             blocks new grants while high
//   req_valid  in   NREQ          per-requester write request
//   req_addr   in   NREQ*ADDR_W   destination index, slice i = [i*ADDR_W +: ADDR_W]
//   req_data   in   NREQ*WIDTH    write data, slice i = [i*WIDTH +: WIDTH]
//   req_ready  out  NREQ          one-hot grant (combinational)
//   wr_data    out  WIDTH         register_file.data_in (registered)
//   wr_en      out  NREGS         register_file.en, one-hot or zero (registered)
//   grant_id   out  clog2(NREQ)   requester whose write is on wr_* (registered)
//   pending    out  NREGS         registers with an accepted, uncommitted write
//   wr_count   out  16            committed writes, wrapping
module regfile_write_arbiter
  import lite16_pkg::*;
#(
  parameter int NREQ   = 3,
  parameter int WIDTH  = LITE16_WIDTH,
  parameter int NREGS  = LITE16_NREGS,
  parameter int ADDR_W = LITE16_ADDR_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     hold,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*WIDTH-1:0]    req_data,
  output logic [NREQ-1:0]          req_ready,
  output logic [WIDTH-1:0]         wr_data,
  output logic [NREGS-1:0]         wr_en,
  output logic [$clog2(NREQ)-1:0]  grant_id,
  output logic [NREGS-1:0]         pending,
  output logic [15:0]              wr_count
);

  localparam int ID_W = $clog2(NREQ);

  logic [ID_W-1:0]   r_ptr;
  logic [WIDTH-1:0]  r_wr_data;
  logic [NREGS-1:0]  r_wr_en;
  logic [ID_W-1:0]   r_grant_id;
  logic [15:0]       r_wr_count;

  logic [NREQ-1:0]   w_gnt;
  logic [ID_W-1:0]   w_gnt_idx;
  logic              w_any;
  logic              w_enable;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [WIDTH-1:0]  w_sel_data;
  logic [NREGS-1:0]  w_sel_onehot;
  logic [ID_W-1:0]   w_ptr_next;

  // Reset gates the grant too, so req_ready drops the moment rst goes low.
  assign w_enable = !hold && rst;

  rr_grant #(.N(NREQ)) u_rr_grant (
    .req     (req_valid),
    .ptr     (r_ptr),
    .enable  (w_enable),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx),
    .any     (w_any)
  );

  assign req_ready = w_gnt;

  // Grant is one-hot, so an OR of the granted slices selects the winner.
  always_comb begin
    w_sel_addr = '0;
    w_sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt[i]) begin
        w_sel_addr = w_sel_addr | req_addr[i*ADDR_W +: ADDR_W];
        w_sel_data = w_sel_data | req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  generate
    if (NREGS == LITE16_NREGS && ADDR_W == LITE16_ADDR_W) begin : g_lite16_en
      assign w_sel_onehot = onehot16(w_sel_addr);
    end else begin : g_generic_en
      assign w_sel_onehot = NREGS'(1) << w_sel_addr;
    end
  endgenerate

  // Pointer moves to the slot just after the winner, wrapping at NREQ.
  assign w_ptr_next = (w_gnt_idx == ID_W'(NREQ - 1)) ? '0 : w_gnt_idx + ID_W'(1);

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!rst) begin
      r_ptr      <= '0;
      r_wr_data  <= '0;
      r_wr_en    <= '0;
      r_grant_id <= '0;
      r_wr_count <= '0;
    end else begin
      // A write on wr_en is captured by register_file at this edge.
      if (|r_wr_en) r_wr_count <= r_wr_count + 16'd1;

      if (w_any) begin
        r_wr_data  <= w_sel_data;
        r_wr_en    <= w_sel_onehot;
        r_grant_id <= w_gnt_idx;
        r_ptr      <= w_ptr_next;
      end else begin
        r_wr_en <= '0;
      end
    end
  end

  assign wr_data  = r_wr_data;
  assign wr_en    = r_wr_en;
  assign grant_id = r_grant_id;
  assign pending  = r_wr_en;
  assign wr_count = r_wr_count;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter (NREQ=3, 16x16 register file).
// A behavioural model of the arbiter and of the downstream register file is
// compared against the DUT on every falling edge; directed sequences add
// hand-computed literal expectations.
module tb_regfile_write_arbiter;

  localparam int NREQ = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hold = 1'b0;
  logic [2:0]  req_valid = '0;
  logic [11:0] req_addr = '0;
  logic [47:0] req_data = '0;

  logic [2:0]  req_ready;
  logic [15:0] wr_data;
  logic [15:0] wr_en;
  logic [1:0]  grant_id;
  logic [15:0] pending;
  logic [15:0] wr_count;

  int n_checks = 0;
  int n_errors = 0;

  regfile_write_arbiter #(.NREQ(NREQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .hold      (hold),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .wr_data   (wr_data),
    .wr_en     (wr_en),
    .grant_id  (grant_id),
    .pending   (pending),
    .wr_count  (wr_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_ptr = 0;
  logic [15:0] m_wr_en = '0;
  logic [15:0] m_wr_data = '0;
  int          m_gid = 0;
  logic [15:0] m_count = '0;
  logic [15:0] m_regs [16] = '{default: 16'h0000};
  int          m_pick;
  logic [2:0]  m_ready;

  // First valid requester at or after p, going round the ring; -1 if none.
  function automatic int model_pick(input int p, input logic [2:0] v);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  always_comb m_pick = model_pick(m_ptr, req_valid);

  always_comb begin
    m_ready = '0;
    if (rst && !hold && m_pick >= 0) m_ready[m_pick] = 1'b1;
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_ptr     <= 0;
      m_wr_en   <= '0;
      m_wr_data <= '0;
      m_gid     <= 0;
      m_count   <= '0;
    end else begin
      if (m_wr_en != 16'h0) m_count <= m_count + 16'd1;
      if (m_ready != 3'b000) begin
        m_wr_en   <= 16'h0001 << req_addr[m_pick*4 +: 4];
        m_wr_data <= req_data[m_pick*16 +: 16];
        m_gid     <= m_pick;
        m_ptr     <= (m_pick + 1) % NREQ;
      end else begin
        m_wr_en <= '0;
      end
    end
  end

  // Downstream register file: captures whatever is on en at each edge.
  always @(posedge clk) begin
    for (int k = 0; k < 16; k++) begin
      if (m_wr_en[k]) m_regs[k] <= m_wr_data;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    check("cyc_req_ready", 32'(req_ready), 32'(m_ready));
    check("cyc_wr_en",     32'(wr_en),     32'(m_wr_en));
    check("cyc_wr_data",   32'(wr_data),   32'(m_wr_data));
    check("cyc_grant_id",  32'(grant_id),  32'(m_gid));
    check("cyc_pending",   32'(pending),   32'(m_wr_en));
    check("cyc_wr_count",  32'(wr_count),  32'(m_count));
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [3:0] a, input logic [15:0] d);
    req_addr[i*4 +: 4]  = a;
    req_data[i*16 +: 16] = d;
  endtask

  int          exp_g [6];
  logic [15:0] exp_en [6];

  initial begin
    exp_g  = '{0, 1, 2, 0, 1, 2};
    exp_en = '{16'h0002, 16'h0008, 16'h0080, 16'h0002, 16'h0008, 16'h0080};

    // Reset with every requester asserting: nothing may be granted.
    #1 rst = 1'b0;
    req_valid = 3'b111;
    #1;
    check("rst_req_ready", 32'(req_ready), 32'h0);
    check("rst_wr_en",     32'(wr_en),     32'h0);
    check("rst_wr_data",   32'(wr_data),   32'h0);
    check("rst_grant_id",  32'(grant_id),  32'h0);
    check("rst_wr_count",  32'(wr_count),  32'h0);
    @(posedge clk);
    #3 rst = 1'b1;
    req_valid = 3'b000;
    step();

    // Single request: requester 1 -> reg 2.
    set_req(1, 4'd2, 16'h2222);
    req_valid = 3'b010;
    #1 check("single_ready", 32'(req_ready), 32'h2);
    step();
    req_valid = 3'b000;
    check("single_wr_en",    32'(wr_en),    32'h0004);
    check("single_wr_data",  32'(wr_data),  32'h2222);
    check("single_grant_id", 32'(grant_id), 32'h1);
    check("single_pending",  32'(pending),  32'h0004);
    step();
    check("single_reg2",     32'(m_regs[2]), 32'h2222);
    check("single_wr_count", 32'(wr_count),  32'h1);
    check("single_wr_en_off", 32'(wr_en),    32'h0);

    // Round robin from ptr=0 with all requesters valid.
    rst = 1'b0;
    #2 rst = 1'b1;
    set_req(0, 4'd1, 16'h1111);
    set_req(1, 4'd3, 16'h3333);
    set_req(2, 4'd7, 16'h7777);
    req_valid = 3'b111;
    #1;
    for (int i = 0; i < 6; i++) begin
      check("rr_ready", 32'(req_ready), 32'(3'b001 << exp_g[i]));
      step();
      check("rr_grant_id", 32'(grant_id), 32'(exp_g[i]));
      check("rr_wr_en",    32'(wr_en),    32'(exp_en[i]));
    end
    req_valid = 3'b000;
    step();
    check("rr_reg3", 32'(m_regs[3]), 32'h3333);

    // Same address from requesters 0 and 2, ptr=0.
    set_req(0, 4'd5, 16'hAAAA);
    set_req(2, 4'd5, 16'hBBBB);
    req_valid = 3'b101;
    #1 check("same_ready0", 32'(req_ready), 32'h1);
    step();
    req_valid = 3'b100;
    check("same_ready2",   32'(req_ready), 32'h4);
    check("same_wr_en0",   32'(wr_en),     32'h0020);
    check("same_wr_data0", 32'(wr_data),   32'hAAAA);
    check("same_pending0", 32'(pending),   32'h0020);
    step();
    req_valid = 3'b000;
    check("same_wr_en1",   32'(wr_en),     32'h0020);
    check("same_wr_data1", 32'(wr_data),   32'hBBBB);
    check("same_pending1", 32'(pending),   32'h0020);
    check("same_grant_id", 32'(grant_id),  32'h2);
    step();
    check("same_reg5", 32'(m_regs[5]), 32'hBBBB);

    // Move ptr to 1, then hold with everyone valid.
    req_valid = 3'b001;
    step();
    req_valid = 3'b000;
    step();
    set_req(0, 4'd1, 16'h1111);
    set_req(1, 4'd3, 16'h3C3C);
    set_req(2, 4'd7, 16'h7777);
    hold = 1'b1;
    req_valid = 3'b111;
    for (int i = 0; i < 4; i++) begin
      check("hold_ready", 32'(req_ready), 32'h0);
      check("hold_wr_en", 32'(wr_en),     32'h0);
      step();
    end
    hold = 1'b0;
    #1 check("hold_release_ready", 32'(req_ready), 32'h2);
    step();
    check("hold_release_gid",  32'(grant_id), 32'h1);
    check("hold_release_en",   32'(wr_en),    32'h0008);

    // Asynchronous reset between edges while reg 3 write is in flight.
    #2 rst = 1'b0;
    #1;
    check("arst_wr_en",     32'(wr_en),     32'h0);
    check("arst_wr_data",   32'(wr_data),   32'h0);
    check("arst_grant_id",  32'(grant_id),  32'h0);
    check("arst_pending",   32'(pending),   32'h0);
    check("arst_req_ready", 32'(req_ready), 32'h0);
    check("arst_wr_count",  32'(wr_count),  32'h0);
    step();
    check("arst_reg3", 32'(m_regs[3]), 32'h3333);
    #2 rst = 1'b1;
    #1 check("arst_release_ready", 32'(req_ready), 32'h1);
    step();
    check("arst_release_gid", 32'(grant_id), 32'h0);
    check("arst_release_en",  32'(wr_en),    32'h0002);

    // Counter wrap: 65536 commits bring wr_count back to 0.
    req_valid = 3'b000;
    rst = 1'b0;
    #2 rst = 1'b1;
    step();
    req_valid = 3'b111;
    for (int i = 0; i < 65536; i++) step();
    req_valid = 3'b000;
    step();
    check("wrap_count_zero", 32'(wr_count), 32'h0);
    check("wrap_model_zero", 32'(m_count),  32'h0);
    req_valid = 3'b001;
    step();
    req_valid = 3'b000;
    step();
    check("wrap_count_one", 32'(wr_count), 32'h1);

    step();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
